// File: rtl/cnn_pkg.sv
// Shared CNN front-end constants: default word sizes and quad phase packing order.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cnn_pkg;

    localparam int DW_DEF = 16;
    localparam int CH_DEF = 3;

    // Phase index 0 occupies the most significant slot of a packed quad.
    localparam int PH_EE = 0;
    localparam int PH_EO = 1;
    localparam int PH_OE = 2;
    localparam int PH_OO = 3;
    localparam int N_PH  = 4;

    function automatic int ph_lsb(input int ph, input int pw);
        return (N_PH - 1 - ph) * pw;
    endfunction

endpackage

// File: rtl/slice_line_buf.sv
// Simple dual-port line buffer holding one even row as {p[2m][2n], p[2m][2n+1]} pairs.
// Latency: registered read, data valid the cycle after rd_en.
// Backpressure: none; caller only strobes wr_en/rd_en on accepted beats.
module slice_line_buf #(
    parameter int DEPTH = 160,
    parameter int WIDTH = 96,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/slice_stream.sv
// Streaming space-to-depth slicer: raster pixels in, one 2x2 quad beat out per output coordinate.
// Latency: out_valid rises the cycle after the accept of the odd/odd pixel of each quad.
// Backpressure: in_ready = !out_valid || out_ready; a stalled output register stalls the input.
module slice_stream
    import cnn_pkg::*;
#(
    parameter int CH    = CH_DEF,
    parameter int DW    = DW_DEF,
    parameter int IMG_W = 320,
    parameter int IMG_H = 320
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH*DW-1:0]  in_data,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*CH*DW-1:0] out_data,
    output logic              out_first,
    output logic              out_last,
    output logic              err_sof
);

    localparam int PW    = CH * DW;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int DEPTH = IMG_W / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    localparam int LSB_EE = ph_lsb(PH_EE, PW);
    localparam int LSB_EO = ph_lsb(PH_EO, PW);
    localparam int LSB_OE = ph_lsb(PH_OE, PW);
    localparam int LSB_OO = ph_lsb(PH_OO, PW);

    logic [CW-1:0]   col, col_eff, col_nxt;
    logic [RW-1:0]   row, row_eff, row_nxt;
    logic [PW-1:0]   pair_reg;
    logic            accept;
    logic            odd_col, odd_row;
    logic            lb_wr, lb_rd, load;
    logic [AW-1:0]   lb_addr;
    logic [2*PW-1:0] lb_rd_data;
    logic [4*PW-1:0] quad;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // in_sof re-anchors the current beat at (0,0) regardless of where the counters were.
    assign col_eff  = in_sof ? '0 : col;
    assign row_eff  = in_sof ? '0 : row;
    assign odd_col  = col_eff[0];
    assign odd_row  = row_eff[0];
    assign lb_addr  = AW'(col_eff >> 1);

    assign lb_wr = accept &&  odd_col && !odd_row;
    assign lb_rd = accept && !odd_col &&  odd_row;
    assign load  = accept &&  odd_col &&  odd_row;

    always_comb begin
        col_nxt = col_eff + CW'(1);
        row_nxt = row_eff;
        if (col_eff == COL_MAX) begin
            col_nxt = '0;
            row_nxt = (row_eff == ROW_MAX) ? '0 : row_eff + RW'(1);
        end
    end

    always_comb begin
        quad = '0;
        quad[LSB_EE +: PW] = lb_rd_data[PW +: PW];
        quad[LSB_EO +: PW] = lb_rd_data[0 +: PW];
        quad[LSB_OE +: PW] = pair_reg;
        quad[LSB_OO +: PW] = in_data;
    end

    // The upper-row pair is prefetched on the even beat so the odd beat sees it combinationally.
    slice_line_buf #(
        .DEPTH (DEPTH),
        .WIDTH (2 * PW),
        .AW    (AW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_wr),
        .wr_addr (lb_addr),
        .wr_data ({pair_reg, in_data}),
        .rd_en   (lb_rd),
        .rd_addr (lb_addr),
        .rd_data (lb_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            pair_reg <= '0;
            err_sof  <= 1'b0;
        end else begin
            err_sof <= accept && in_sof && ((col != '0) || (row != '0));
            if (accept) begin
                col <= col_nxt;
                row <= row_nxt;
                if (!odd_col) begin
                    pair_reg <= in_data;
                end
            end
        end
    end

    // Loading only happens on an accept, which implies the register is free or draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= quad;
            out_first <= (row_eff == RW'(1)) && (col_eff == CW'(1));
            out_last  <= (row_eff == ROW_MAX) && (col_eff == COL_MAX);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_slice_stream.sv
// Directed bench for slice_stream: 4x4 single-channel frames plus a 4x2 three-channel instance.
module tb_slice_stream;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [7:0]  in_data = '0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, out_first, out_last, err_sof;
    logic [31:0] out_data;

    logic         in_valid3 = 1'b0;
    logic         in_sof3 = 1'b0;
    logic [47:0]  in_data3 = '0;
    logic         out_ready3 = 1'b1;
    logic         in_ready3, out_valid3, out_first3, out_last3, err_sof3;
    logic [191:0] out_data3;

    slice_stream #(.CH(1), .DW(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_last(out_last), .err_sof(err_sof)
    );

    slice_stream #(.CH(3), .DW(16), .IMG_W(4), .IMG_H(2)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .in_sof(in_sof3), .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .out_first(out_first3), .out_last(out_last3), .err_sof(err_sof3)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        f;
        logic        l;
    } beat_t;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        e_v;
        logic [31:0] e_d;
        logic        e_f;
        logic        e_l;
    } vec_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    err_cnt = 0;
    bit    rand_rdy = 1'b0;
    logic  rdy_hold = 1'b1;
    beat_t got_q[$];
    beat_t exp_q[$];
    vec_t  tbl[16];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] px(input int f, input int r, input int c);
        return 8'(f * 64 + r * 16 + c);
    endfunction

    function automatic logic [47:0] pix3(input int r, input int c);
        logic [15:0] rc;
        rc = 16'(r * 16 + c);
        return {16'h0A00 | rc, 16'h0B00 | rc, 16'h0C00 | rc};
    endfunction

    function automatic beat_t ref_beat(input int f, input int m, input int n);
        beat_t b;
        b.d = {px(f, 2*m, 2*n), px(f, 2*m, 2*n+1), px(f, 2*m+1, 2*n), px(f, 2*m+1, 2*n+1)};
        b.f = (m == 0) && (n == 0);
        b.l = (m == H/2-1) && (n == W/2-1);
        return b;
    endfunction

    // Output sink and error-pulse counter, sampled mid-cycle.
    always @(negedge clk) begin
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_hold;
        #2;
        if (out_valid && out_ready) got_q.push_back('{d: out_data, f: out_first, l: out_last});
        if (err_sof) err_cnt++;
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [7:0] d, input logic sof, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk); #2;
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: pixel %0h never accepted", d);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int f, input logic sof_first, input int gapmax);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(px(f, r, c), sof_first && r == 0 && c == 0, $urandom_range(0, gapmax));
    endtask

    task automatic push_frame_ref(input int f);
        for (int m = 0; m < H/2; m++)
            for (int n = 0; n < W/2; n++)
                exp_q.push_back(ref_beat(f, m, n));
    endtask

    task automatic check_beats(input string name);
        for (int t = 0; t < 300 && got_q.size() < exp_q.size(); t++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_count"}, 192'(got_q.size()), 192'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", name, i), 192'(got_q[i]), 192'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, px(0, i/4, i%4), 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'h11, 1'b1, 32'h00011011, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 8'h13, 1'b1, 32'h02031213, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 8'h31, 1'b1, 32'h20213031, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 8'h33, 1'b1, 32'h22233233, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 192'({out_valid, out_data, out_first, out_last, err_sof, in_ready}),
            192'({1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}));
        chk("reset_state3", 192'({out_valid3, out_first3, out_last3, err_sof3, in_ready3}), 192'(5'b00001));
        chk("reset_data3", out_data3, 192'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Continuous frame, out_ready high, cycle-by-cycle table
        for (int i = 0; i < 16; i++) begin
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            @(negedge clk); #2;
            chk($sformatf("tbl%0d_in_ready", i), 192'(in_ready), 192'(1'b1));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_vld_err", i), 192'({out_valid, err_sof}), 192'({tbl[i].e_v, 1'b0}));
            if (tbl[i].e_v)
                chk($sformatf("tbl%0d_beat", i), 192'({out_data, out_first, out_last}),
                    192'({tbl[i].e_d, tbl[i].e_f, tbl[i].e_l}));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("tbl_drained", 192'(out_valid), 192'(1'b0));
        got_q.delete();

        // Backpressure: stall the first beat for 10 cycles
        for (int i = 0; i < 6; i++) send(px(1, i/4, i%4), 1'b0, 0);
        rdy_hold  = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = px(1, 1, 2);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk); #2;
            chk($sformatf("stall%0d", t), 192'({in_ready, out_valid, out_data, out_first}),
                192'({1'b0, 1'b1, 32'h40415051, 1'b1}));
            @(posedge clk); #1;
        end
        rdy_hold = 1'b1;
        for (int i = 6; i < 16; i++) send(px(1, i/4, i%4), 1'b0, 0);
        push_frame_ref(1);
        check_beats("bp");

        // Three back-to-back frames, random gaps and random out_ready; legal sof on frame 1
        err_cnt  = 0;
        rand_rdy = 1'b1;
        for (int f = 0; f < 3; f++) begin
            send_frame(f, f == 1, 2);
            push_frame_ref(f);
        end
        check_beats("rand");
        rand_rdy = 1'b0;
        chk("rand_no_err", 192'(err_cnt), 192'(0));

        // Resync: sof lands where pixel (2,1) of the first frame was due
        err_cnt = 0;
        for (int i = 0; i < 9; i++) send(px(0, i/4, i%4), 1'b0, 0);
        send_frame(3, 1'b1, 0);
        exp_q.push_back(ref_beat(0, 0, 0));
        exp_q.push_back(ref_beat(0, 0, 1));
        push_frame_ref(3);
        check_beats("resync");
        chk("resync_err_pulses", 192'(err_cnt), 192'(1));

        // Reset in the middle of row 3, then a clean frame
        for (int i = 0; i < 13; i++) send(px(1, i/4, i%4), 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_beats", 192'(got_q.size()), 192'(2));
        got_q.delete();
        rst = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk); #2;
            chk($sformatf("in_reset%0d", t), 192'({out_valid, out_data, out_first, out_last, err_sof, in_ready}),
                192'({1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        send_frame(2, 1'b0, 0);
        push_frame_ref(2);
        check_beats("post_reset");

        // Three channels: channel 0 stays in the MSBs of each phase word
        for (int i = 0; i < 8; i++) begin
            in_valid3 = 1'b1;
            in_data3  = pix3(i/4, i%4);
            @(posedge clk); #1;
            if (i == 5) begin
                chk("ch3_beat0", out_data3, {pix3(0, 0), pix3(0, 1), pix3(1, 0), pix3(1, 1)});
                chk("ch3_beat0_flags", 192'({out_valid3, out_first3, out_last3}), 192'(3'b110));
                chk("ch3_msb_ch0", 192'(out_data3[191:160]), 192'(32'h0A000B00));
                chk("ch3_lsb_ch2", 192'(out_data3[15:0]), 192'(16'h0C11));
            end
            if (i == 7) begin
                chk("ch3_beat1", out_data3, {pix3(0, 2), pix3(0, 3), pix3(1, 2), pix3(1, 3)});
                chk("ch3_beat1_flags", 192'({out_valid3, out_first3, out_last3}), 192'(3'b101));
            end
        end
        in_valid3 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
